// File: rtl/cycle_walker.sv
// Walks predecessor pointers of the relaxed vertex table until it is on a cycle,
// then streams that cycle's vertex IDs over a valid/ready handshake.
module cycle_walker #(
  parameter int unsigned NODES = 127,
  parameter int unsigned VW    = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [VW-1:0] start_vert,
  output logic          busy,
  output logic          done,
  output logic          found,
  output logic          vert_rd,
  output logic [VW-1:0] vert_addr,
  input  logic [31:0]   vert_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [VW-1:0] out_vert,
  output logic          out_last
);

  localparam int unsigned CW = $clog2(NODES + 2);
  localparam logic [CW-1:0] STEP_LIMIT = CW'(NODES + 1);
  localparam logic [17:0]   DIST_INF   = 18'h3FFFF;

  typedef enum logic [2:0] {
    IDLE,
    WALK_RD,
    WALK_WAIT,
    EMIT_RD,
    EMIT_WAIT,
    EMIT_OUT,
    FINISH
  } state_t;

  state_t        state_q, state_d;
  logic [VW-1:0] cur_q, cur_d;
  logic [VW-1:0] anchor_q, anchor_d;
  logic [VW-1:0] nxt_q, nxt_d;
  logic [CW-1:0] steps_q, steps_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          found_q, found_d;
  logic          vert_rd_q, vert_rd_d;
  logic [VW-1:0] vert_addr_q, vert_addr_d;
  logic          out_valid_q, out_valid_d;
  logic [VW-1:0] out_vert_q, out_vert_d;
  logic          out_last_q, out_last_d;

  logic [VW-1:0] rd_pred;
  logic          rd_unreach;
  logic          unused_rdata;

  assign rd_pred      = vert_rdata[18 +: VW];
  assign rd_unreach   = (vert_rdata[17:0] == DIST_INF);
  assign unused_rdata = ^vert_rdata[31:18+VW];

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    anchor_d = anchor_q;
    nxt_d    = nxt_q;
    steps_d  = steps_q;
    found_d  = found_q;
    out_last_d = out_last_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          cur_d   = start_vert;
          steps_d = '0;
          found_d = 1'b0;
          state_d = WALK_RD;
        end
      end
      WALK_RD: state_d = WALK_WAIT;
      WALK_WAIT: begin
        if (rd_unreach) begin
          found_d = 1'b0;
          state_d = FINISH;
        end else begin
          steps_d = steps_q + 1'b1;
          // The final read sees the vertex reached after NODES hops, which is
          // already on the cycle; it becomes the anchor and emission starts there.
          if (steps_d == STEP_LIMIT) begin
            anchor_d = cur_q;
            steps_d  = '0;
            state_d  = EMIT_RD;
          end else begin
            cur_d   = rd_pred;
            state_d = WALK_RD;
          end
        end
      end
      EMIT_RD: state_d = EMIT_WAIT;
      EMIT_WAIT: begin
        if (rd_unreach) begin
          found_d = 1'b0;
          state_d = FINISH;
        end else begin
          nxt_d      = rd_pred;
          out_last_d = (rd_pred == anchor_q) || (steps_q >= STEP_LIMIT);
          state_d    = EMIT_OUT;
        end
      end
      EMIT_OUT: begin
        if (out_ready) begin
          if (out_last_q) begin
            found_d = 1'b1;
            state_d = FINISH;
          end else begin
            cur_d   = nxt_q;
            steps_d = steps_q + 1'b1;
            state_d = EMIT_RD;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d != IDLE) && (state_d != FINISH);
    done_d      = (state_d == FINISH);
    vert_rd_d   = (state_d == WALK_RD) || (state_d == EMIT_RD);
    vert_addr_d = vert_rd_d ? cur_d : '0;
    out_valid_d = (state_d == EMIT_OUT);
    out_vert_d  = out_valid_d ? cur_d : '0;
    if (!out_valid_d) begin
      out_last_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      anchor_q    <= '0;
      nxt_q       <= '0;
      steps_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      found_q     <= 1'b0;
      vert_rd_q   <= 1'b0;
      vert_addr_q <= '0;
      out_valid_q <= 1'b0;
      out_vert_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      anchor_q    <= anchor_d;
      nxt_q       <= nxt_d;
      steps_q     <= steps_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      found_q     <= found_d;
      vert_rd_q   <= vert_rd_d;
      vert_addr_q <= vert_addr_d;
      out_valid_q <= out_valid_d;
      out_vert_q  <= out_vert_d;
      out_last_q  <= out_last_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign found     = found_q;
  assign vert_rd   = vert_rd_q;
  assign vert_addr = vert_addr_q;
  assign out_valid = out_valid_q;
  assign out_vert  = out_vert_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_cycle_walker.sv
// Scoreboard bench for cycle_walker: a reference model fills expectation queues,
// an independent monitor pops them whenever the DUT hands out a beat or a done.
module tb_cycle_walker;

  localparam int N  = 7;
  localparam int VW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [VW-1:0] start_vert;
  logic          busy, done, found, vert_rd;
  logic [VW-1:0] vert_addr;
  logic [31:0]   vert_rdata;
  logic          out_valid, out_ready, out_last;
  logic [VW-1:0] out_vert;

  cycle_walker #(.NODES(N), .VW(VW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .start_vert(start_vert),
    .busy      (busy),
    .done      (done),
    .found     (found),
    .vert_rd   (vert_rd),
    .vert_addr (vert_addr),
    .vert_rdata(vert_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vert  (out_vert),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:N];
  always @(posedge clk) if (vert_rd) vert_rdata <= mem[vert_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int vert; int last; } beat_t;
  beat_t exp_q[$];
  int    exp_found[$];

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int first_cyc = 0;
  bit first_seen = 0;
  int rdy_mode = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void set_entry(input int v, input int p, input int d);
    mem[v] = {7'd0, 7'(p), 18'(d)};
  endfunction

  function automatic int pred_of(input int v);
    logic [31:0] e;
    e = mem[v];
    return int'(e[20:18]);
  endfunction

  function automatic bit unreach(input int v);
    logic [31:0] e;
    e = mem[v];
    return e[17:0] == 18'h3FFFF;
  endfunction

  // Reference: the vertex N hops from the start lies on the cycle; every vertex
  // visited on the way (N+1 of them) must be reachable. Emit walks the cycle once.
  task automatic model(input int s);
    int v, u, beats;
    bit last;
    v = s;
    for (int i = 0; i <= N; i++) begin
      if (unreach(v)) begin
        exp_found.push_back(0);
        return;
      end
      if (i < N) v = pred_of(v);
    end
    u = v;
    beats = 0;
    forever begin
      if (unreach(u)) begin
        exp_found.push_back(0);
        return;
      end
      last = (pred_of(u) == v) || (beats >= N + 1);
      exp_q.push_back('{vert: u, last: int'(last)});
      beats++;
      if (last) begin
        exp_found.push_back(1);
        return;
      end
      u = pred_of(u);
    end
  endtask

  // Downstream ready: 0 = always, 1 = random, 2 = five stall cycles per beat.
  initial begin
    int scnt;
    scnt = 0;
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: begin
          if (!out_valid) begin
            out_ready = 1'b0;
            scnt = 0;
          end else if (scnt < 5) begin
            out_ready = 1'b0;
            scnt++;
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase
    end
  end

  // Monitor
  initial begin
    bit   stall_p;
    int   p_vert, p_last;
    beat_t e;
    stall_p = 0;
    p_vert = 0;
    p_last = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_p = 0;
        continue;
      end
      if (stall_p) begin
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_vert", int'(out_vert), p_vert);
        chk("stall_last", int'(out_last), p_last);
      end
      if (out_valid && !first_seen) begin
        first_seen = 1;
        first_cyc  = cyc;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("extra_beat", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("beat_vert", int'(out_vert), e.vert);
          chk("beat_last", int'(out_last), e.last);
        end
      end
      stall_p = out_valid && !out_ready;
      p_vert  = int'(out_vert);
      p_last  = int'(out_last);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_busy_low", int'(busy), 0);
        if (exp_found.size() == 0) chk("extra_done", 1, 0);
        else chk("found", int'(found), exp_found.pop_front());
      end
    end
  end

  task automatic pulse_start(input int s, output int s_cyc);
    @(posedge clk);
    #1;
    start_vert = VW'(s);
    start = 1'b1;
    s_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run(input int s, input int mode, input int lat_v, input int lat_d, input bit restart);
    int s_cyc, d0, dummy;
    model(s);
    rdy_mode = mode;
    first_seen = 0;
    d0 = done_cnt;
    pulse_start(s, s_cyc);
    @(negedge clk);
    chk("busy_after_start", int'(busy), 1);
    if (restart) begin
      repeat (4) @(posedge clk);
      pulse_start((s + 1) % (N + 1), dummy);
    end
    for (int i = 0; i < 1000 && done_cnt == d0; i++) @(posedge clk);
    chk("done_seen", int'(done_cnt != d0), 1);
    @(posedge clk);
    chk("beats_drained", exp_q.size(), 0);
    chk("found_drained", exp_found.size(), 0);
    if (lat_v >= 0) chk("first_valid_latency", first_cyc - s_cyc, lat_v);
    if (lat_d >= 0) chk("done_latency", done_cyc - s_cyc, lat_d);
    if (restart) begin
      repeat (40) @(posedge clk);
      chk("single_done", done_cnt - d0, 1);
    end
  endtask

  initial begin
    int dummy;
    reset = 1'b1;
    start = 1'b0;
    start_vert = '0;
    for (int v = 0; v <= N; v++) set_entry(v, 0, 10);
    set_entry(3, 5, 100);
    set_entry(5, 6, 120);
    set_entry(6, 2, 90);
    set_entry(2, 5, 80);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_found", int'(found), 0);
    chk("rst_vert_rd", int'(vert_rd), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_out_vert", int'(out_vert), 0);
    chk("rst_vert_addr", int'(vert_addr), 0);
    @(negedge clk);
    reset = 1'b0;

    // T1: beats 5,6,2
    run(3, 0, 2*(N+1)+3, 2*(N+1)+10, 0);
    repeat (3) @(negedge clk);
    chk("found_hold", int'(found), 1);
    chk("done_pulse", int'(done), 0);

    // T2: self-loop
    set_entry(4, 4, 50);
    run(4, 0, 2*(N+1)+3, 2*(N+1)+4, 0);

    // T3: unreachable start
    set_entry(1, 0, 18'h3FFFF);
    run(1, 0, -1, 3, 0);
    repeat (2) @(negedge clk);
    chk("found_hold_zero", int'(found), 0);

    // T4: stalled downstream
    run(3, 2, 2*(N+1)+3, -1, 0);

    // T5: second start while busy
    run(3, 0, 2*(N+1)+3, 2*(N+1)+10, 1);

    // T6: reset while presenting a beat
    model(3);
    rdy_mode = 2;
    pulse_start(3, dummy);
    for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
    chk("t6_valid_seen", int'(out_valid), 1);
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_out_valid", int'(out_valid), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_done", int'(done), 0);
    chk("t6_vert_rd", int'(vert_rd), 0);
    exp_q.delete();
    exp_found.delete();
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b0;
    run(3, 2, 2*(N+1)+3, -1, 0);

    // Random graphs, random ready
    for (int t = 0; t < 25; t++) begin
      for (int v = 0; v <= N; v++)
        set_entry(v, int'($urandom_range(0, N)),
                  ($urandom_range(0, 9) == 0) ? 18'h3FFFF : int'($urandom_range(0, 1000)));
      run(int'($urandom_range(0, N)), 1, -1, -1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
